// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the MD state encoding and the forward-select width helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int FWD_RF = 0;

  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Priority forward matcher for one source operand.
// Youngest matching stage wins; flags loads not yet forwardable.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FW         = fwd_w(FWD_DEPTH)
) (
  input  logic [REG_AW-1:0]           rn_i,
  input  logic                        en_i,
  input  logic [FWD_DEPTH-1:0]        st_wreg_i,
  input  logic [FWD_DEPTH*REG_AW-1:0] st_rn_i,
  input  logic [FWD_DEPTH-1:0]        st_m2reg_i,
  output logic [FW-1:0]               sel_o,
  output logic                        load_stall_o
);

  // Scan oldest to youngest so the youngest match is written last.
  always_comb begin
    sel_o        = FW'(FWD_RF);
    load_stall_o = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (en_i && (rn_i != '0) && st_wreg_i[k-1] &&
          (st_rn_i[(k-1)*REG_AW +: REG_AW] == rn_i)) begin
        sel_o        = FW'(k);
        load_stall_o = (k < LOAD_STAGE) && st_m2reg_i[k-1];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding and MD busy tracking beside ID.
// Optional perf counters: define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LAT     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [REG_AW-1:0]             id_rs,
  input  logic [REG_AW-1:0]             id_rt,
  input  logic                          id_use_rs,
  input  logic                          id_use_rt,
  input  logic                          id_md_start,
  input  logic                          id_md_use,
  input  logic                          id_branch_taken,
  input  logic [FWD_DEPTH-1:0]          st_wreg,
  input  logic [FWD_DEPTH*REG_AW-1:0]   st_rn,
  input  logic [FWD_DEPTH-1:0]          st_m2reg,
  output logic [fwd_w(FWD_DEPTH)-1:0]   fwda,
  output logic [fwd_w(FWD_DEPTH)-1:0]   fwdb,
  output logic                          wpcir,
  output logic                          flush_if,
  output logic                          md_busy,
  output logic                          md_done
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   flush_cnt
`endif
);

  localparam int FW = fwd_w(FWD_DEPTH);
  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

  logic stall_a, stall_b, load_stall, md_stall, md_go;

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  fwd_sel #(
    .REG_AW    (REG_AW),
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_STAGE(LOAD_STAGE),
    .FW        (FW)
  ) u_fwd_a (
    .rn_i        (id_rs),
    .en_i        (id_use_rs),
    .st_wreg_i   (st_wreg),
    .st_rn_i     (st_rn),
    .st_m2reg_i  (st_m2reg),
    .sel_o       (fwda),
    .load_stall_o(stall_a)
  );

  fwd_sel #(
    .REG_AW    (REG_AW),
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_STAGE(LOAD_STAGE),
    .FW        (FW)
  ) u_fwd_b (
    .rn_i        (id_rt),
    .en_i        (id_use_rt),
    .st_wreg_i   (st_wreg),
    .st_rn_i     (st_rn),
    .st_m2reg_i  (st_m2reg),
    .sel_o       (fwdb),
    .load_stall_o(stall_b)
  );

  assign load_stall = stall_a | stall_b;
  assign md_busy    = (state_q == BUSY);
  assign md_done    = (state_q == DONE);
  assign md_stall   = id_md_use & md_busy;
  assign wpcir      = ~(load_stall | md_stall);
  assign flush_if   = id_branch_taken & wpcir;
  assign md_go      = id_md_start & wpcir;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_go) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        // Back-to-back ops skip IDLE entirely.
        if (md_go) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!wpcir && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_if && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus against a timeline-based reference model.
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int D   = 3;
  localparam int LS  = 2;
  localparam int LAT = 4;
  localparam int FW  = $clog2(D + 1);

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   id_rs, id_rt;
  logic            id_use_rs, id_use_rt;
  logic            id_md_start, id_md_use, id_branch_taken;
  logic [D-1:0]    st_wreg, st_m2reg;
  logic [D*AW-1:0] st_rn;
  logic [FW-1:0]   fwda, fwdb;
  logic            wpcir, flush_if, md_busy, md_done;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]     stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .REG_AW(AW), .FWD_DEPTH(D), .LOAD_STAGE(LS), .MD_LAT(LAT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_md_start    (id_md_start),
    .id_md_use      (id_md_use),
    .id_branch_taken(id_branch_taken),
    .st_wreg        (st_wreg),
    .st_rn          (st_rn),
    .st_m2reg       (st_m2reg),
    .fwda           (fwda),
    .fwdb           (fwdb),
    .wpcir          (wpcir),
    .flush_if       (flush_if),
    .md_busy        (md_busy),
    .md_done        (md_done)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int md_s   = -1000;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Youngest writing stage whose destination matches wins.
  function automatic void ref_fwd(input logic [AW-1:0] r,
                                  input logic en,
                                  output int sel, output bit ls);
    sel = 0;
    ls  = 0;
    for (int k = 1; k <= D; k++) begin
      if (sel == 0 && en && r != 0 && st_wreg[k-1] &&
          st_rn[(k-1)*AW +: AW] == r) begin
        sel = k;
        ls  = (k < LS) && st_m2reg[k-1];
      end
    end
  endfunction

  // MD op accepted at cycle s: busy s+1..s+LAT, done at s+LAT+1.
  task automatic step();
    int sa, sb;
    bit la, lb, busy, done, wp, fl;
    #1;
    ref_fwd(id_rs, id_use_rs, sa, la);
    ref_fwd(id_rt, id_use_rt, sb, lb);
    busy = (cyc >= md_s + 1) && (cyc <= md_s + LAT);
    done = (cyc == md_s + LAT + 1);
    wp   = !(la || lb || (id_md_use && busy));
    fl   = id_branch_taken && wp;
    chk("fwda",     32'(fwda),     32'(sa));
    chk("fwdb",     32'(fwdb),     32'(sb));
    chk("wpcir",    32'(wpcir),    32'(wp));
    chk("flush_if", 32'(flush_if), 32'(fl));
    chk("md_busy",  32'(md_busy),  32'(busy));
    chk("md_done",  32'(md_done),  32'(done));
    if (id_md_start && wp && !busy && !reset) md_s = cyc;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle_in();
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_md_start = 0; id_md_use = 0; id_branch_taken = 0;
    st_wreg = '0; st_rn = '0; st_m2reg = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    md_s = -1000;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    @(negedge clock);
    @(negedge clock);
    step();
    chk("reset_wpcir", 32'(wpcir), 32'd1);
    reset = 1'b0;
    tick();

    // Youngest of two matching stages is selected.
    st_wreg = 3'b011;
    st_rn   = {5'd0, 5'd3, 5'd3};
    id_rs = 5'd3; id_use_rs = 1;
    step();
    chk("dir_fwda_young", 32'(fwda), 32'd1);
    chk("dir_wpcir_fwd",  32'(wpcir), 32'd1);
    tick();

    // Load-use in stage 1 stalls and suppresses the flush.
    idle_in();
    st_wreg = 3'b001; st_m2reg = 3'b001;
    st_rn   = {5'd0, 5'd0, 5'd5};
    id_rt = 5'd5; id_use_rt = 1; id_branch_taken = 1;
    step();
    chk("dir_load_wpcir", 32'(wpcir), 32'd0);
    chk("dir_load_flush", 32'(flush_if), 32'd0);
    tick();
    st_wreg = 3'b010; st_m2reg = 3'b010;
    st_rn   = {5'd0, 5'd5, 5'd0};
    step();
    chk("dir_load_fwdb", 32'(fwdb), 32'd2);
    chk("dir_load_go",   32'(wpcir), 32'd1);
    tick();

    // Register 0 is never forwarded.
    idle_in();
    st_wreg = 3'b111; id_rs = 5'd0; id_use_rs = 1;
    step();
    chk("dir_r0_fwda",  32'(fwda), 32'd0);
    chk("dir_r0_wpcir", 32'(wpcir), 32'd1);
    tick();

    // Single MD op: busy t1..t4, done t5.
    idle_in();
    for (int t = 0; t <= 6; t++) begin
      id_md_start = (t == 0);
      id_md_use   = (t == 2) || (t == 5);
      step();
      chk("dir_md_busy", 32'(md_busy), 32'((t >= 1) && (t <= 4)));
      chk("dir_md_done", 32'(md_done), 32'(t == 5));
      if (t == 2) chk("dir_md_stall", 32'(wpcir), 32'd0);
      if (t == 5) chk("dir_md_free",  32'(wpcir), 32'd1);
      tick();
    end

    // Back-to-back ops: done pulses at t5 and t10, no idle gap.
    idle_in();
    for (int t = 0; t <= 11; t++) begin
      id_md_start = (t == 0) || (t == 5);
      step();
      chk("b2b_done", 32'(md_done), 32'((t == 5) || (t == 10)));
      chk("b2b_busy", 32'(md_busy),
          32'(((t >= 1) && (t <= 4)) || ((t >= 6) && (t <= 9))));
      tick();
    end

    // Reset in the middle of BUSY.
    idle_in();
    id_md_start = 1;
    step();
    tick();
    id_md_start = 0;
    step();
    tick();
    do_reset();
    id_md_use = 1;
    step();
    chk("post_rst_wpcir", 32'(wpcir), 32'd1);
    tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_in();
        do_reset();
      end
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
      id_use_rs = 1'($urandom_range(0, 3) != 0);
      id_use_rt = 1'($urandom_range(0, 3) != 0);
      id_md_start = 1'($urandom_range(0, 5) == 0);
      id_md_use = 1'($urandom_range(0, 2) == 0);
      id_branch_taken = 1'($urandom_range(0, 3) == 0);
      st_wreg  = D'($urandom);
      st_m2reg = D'($urandom);
      for (int k = 0; k < D; k++)
        st_rn[k*AW +: AW] = AW'($urandom_range(0, 3));
      step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
